// File: rtl/softmax_exp_index_gen_if.sv
// Logit input channel, LUT-index output channel and busy flag for softmax_exp_index_gen.
// The slave modport is the block's view; master is the surrounding pipeline's view.
interface softmax_exp_index_gen_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_logit;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_x;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;

  modport slave (
    input  in_valid, in_logit, out_ready,
    output in_ready, out_valid, out_x, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_logit, out_ready,
    input  in_ready, out_valid, out_x, out_idx, out_last, busy
  );
endinterface

// File: rtl/softmax_exp_index_gen.sv
// Buffers one frame of signed logits while tracking its minimum, then emits
// one saturated 8-bit exp-LUT index per class: sat8((logit - min) >>> FRAC_BITS).
module softmax_exp_index_gen #(
  parameter int unsigned N_CLASSES = 10,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  softmax_exp_index_gen_if.slave  bus
);

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_CLASSES - 1);
  localparam logic signed [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  typedef enum logic {COLLECT, EMIT} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] min_q, min_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               out_x_q, out_x_d;
  logic [IDX_W-1:0]         out_idx_q, out_idx_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic signed [DATA_W-1:0] buf_q [N_CLASSES];

  logic                     in_fire;
  logic                     out_fire;
  logic [IDX_W-1:0]         next_idx;

  // Difference is taken one bit wider so the full signed span cannot wrap.
  function automatic logic [7:0] lut_idx(input logic signed [DATA_W-1:0] v,
                                         input logic signed [DATA_W-1:0] m);
    logic [DATA_W:0] d;
    logic [DATA_W:0] s;
    d = {v[DATA_W-1], v} - {m[DATA_W-1], m};
    s = d >> FRAC_BITS;
    if (s > (DATA_W+1)'(255)) return 8'hFF;
    return s[7:0];
  endfunction

  assign in_fire  = (state_q == COLLECT) && bus.in_valid && in_ready_q;
  assign out_fire = (state_q == EMIT) && out_valid_q && bus.out_ready;
  assign next_idx = count_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    min_d       = min_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    case (state_q)
      COLLECT: begin
        if (in_fire) begin
          busy_d = 1'b1;
          if (count_q == '0 || bus.in_logit < min_q) min_d = bus.in_logit;
          if (count_q == LAST_IDX) begin
            // Class 0 was buffered earlier; its index uses the final minimum.
            state_d     = EMIT;
            count_d     = '0;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_x_d     = lut_idx(buf_q[0], min_d);
            out_idx_d   = '0;
            out_last_d  = 1'b0;
          end else begin
            count_d = next_idx;
          end
        end
      end
      EMIT: begin
        if (out_fire) begin
          if (out_last_q) begin
            state_d     = COLLECT;
            count_d     = '0;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_x_d     = '0;
            out_idx_d   = '0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
          end else begin
            count_d    = next_idx;
            out_x_d    = lut_idx(buf_q[next_idx], min_q);
            out_idx_d  = next_idx;
            out_last_d = (next_idx == LAST_IDX);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      count_q     <= '0;
      min_q       <= MOST_POS;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      min_q       <= min_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  // Frame storage needs no reset; stale contents are always overwritten before use.
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[count_q] <= bus.in_logit;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_softmax_exp_index_gen.sv
// Directed bench for softmax_exp_index_gen: hand-computed frames, back-pressure,
// saturation, truncation and mid-frame reset.
module tb_softmax_exp_index_gen;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  softmax_exp_index_gen_if #(.DATA_W(16), .IDX_W(4)) bus ();

  softmax_exp_index_gen #(
    .N_CLASSES(10), .DATA_W(16), .FRAC_BITS(8), .IDX_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_frame(input logic [15:0] v [10]);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_logit = v[i];
      @(negedge clk);
      chk("in_ready_collect", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Collects ten indices under random stalls; leaves in_valid low before frame end.
  task automatic collect_frame(input logic [7:0] exp_x [10], input int stall_pct);
    int         got = 0;
    logic       stalled = 1'b0;
    logic [7:0] px = '0;
    logic [3:0] pidx = '0;
    logic       plast = 1'b0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      bus.out_ready = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      if (stalled) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_x", 32'(bus.out_x), 32'(px));
        chk("stall_idx", 32'(bus.out_idx), 32'(pidx));
        chk("stall_last", 32'(bus.out_last), 32'(plast));
      end
      if (bus.out_valid) chk("in_ready_emit", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        chk("out_x", 32'(bus.out_x), 32'(exp_x[got]));
        chk("out_idx", 32'(bus.out_idx), 32'(got));
        chk("out_last", 32'(bus.out_last), 32'(got == 9));
        got++;
        if (got == 10) bus.in_valid = 1'b0;
      end
      stalled = bus.out_valid && !bus.out_ready;
      px      = bus.out_x;
      pidx    = bus.out_idx;
      plast   = bus.out_last;
      @(posedge clk);
      #1;
    end
    chk("frame_count", 32'(got), 32'd10);
    bus.out_ready = 1'b0;
    chk("end_valid", 32'(bus.out_valid), 32'd0);
    chk("end_in_ready", 32'(bus.in_ready), 32'd1);
    chk("end_busy", 32'(bus.busy), 32'd0);
  endtask

  task automatic after_push();
    chk("first_valid", 32'(bus.out_valid), 32'd1);
    chk("first_in_ready", 32'(bus.in_ready), 32'd0);
    chk("first_busy", 32'(bus.busy), 32'd1);
  endtask

  logic [15:0] f_ramp [10];
  logic [7:0]  x_ramp [10];
  logic [15:0] f_eq   [10];
  logic [7:0]  x_zero [10];
  logic [15:0] f_ext  [10];
  logic [7:0]  x_ext  [10];
  logic [15:0] f_frac [10];
  logic [7:0]  x_frac [10];
  logic [15:0] f_desc [10];
  logic [7:0]  x_desc [10];

  initial begin
    f_ramp = '{16'd0, 16'd256, 16'd512, 16'd768, 16'd1024,
               16'd1280, 16'd1536, 16'd1792, 16'd2048, 16'd2304};
    x_ramp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    f_eq   = '{default: 16'h1234};
    x_zero = '{default: 8'd0};
    // -32768, 32767, 0, 256, -256, 100, -100, 1000, 5000, -5000
    f_ext  = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0100, 16'hFF00,
               16'h0064, 16'hFF9C, 16'h03E8, 16'h1388, 16'hEC78};
    x_ext  = '{8'd0, 8'd255, 8'd128, 8'd129, 8'd127,
               8'd128, 8'd127, 8'd131, 8'd147, 8'd108};
    f_frac = '{16'h0000, 16'h01FF, 16'h00FF, 16'h0100, 16'h0200,
               16'h02FF, 16'h007F, 16'h0300, 16'h0001, 16'h4000};
    x_frac = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd2, 8'd0, 8'd3, 8'd0, 8'd64};
    f_desc = '{16'd2304, 16'd2048, 16'd1792, 16'd1536, 16'd1280,
               16'd1024, 16'd768, 16'd512, 16'd256, 16'd0};
    x_desc = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

    bus.in_valid  = 1'b0;
    bus.in_logit  = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_x", 32'(bus.out_x), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Ramp, no back-pressure.
    push_frame(f_ramp);
    after_push();
    collect_frame(x_ramp, 0);

    // All equal; in_valid held high during emission must be ignored.
    push_frame(f_eq);
    after_push();
    bus.in_valid = 1'b1;
    bus.in_logit = 16'h7FFF;
    collect_frame(x_zero, 0);

    // Extreme range.
    push_frame(f_ext);
    after_push();
    collect_frame(x_ext, 0);

    // Ramp under random back-pressure.
    push_frame(f_ramp);
    after_push();
    collect_frame(x_ramp, 50);

    // Fractional truncation.
    push_frame(f_frac);
    after_push();
    collect_frame(x_frac, 30);

    // Reset after five accepted logits discards the partial frame.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_logit = 16'h8000;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    chk("partial_busy", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_frame(f_desc);
    after_push();
    collect_frame(x_desc, 20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
